// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller for IF/ID, PC and ID/EX: load-use, branch/jump flush,
// multi-cycle multiply/divide freeze and exception redirect. Optional stall counter: HAZARD_STALL_COUNT_EN.
module hazard_ctrl #(
   parameter int MD_LATENCY = 32,
   parameter int CNT_W      = 6
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [4:0]  idRs,
   input  logic [4:0]  idRt,
   input  logic        exMemRead,
   input  logic [4:0]  exRt,
   input  logic        branchTaken,
   input  logic        jump,
   input  logic        mdStart,
   input  logic        excReq,
   output logic        pcWrite,
   output logic        IFIDWrite,
   output logic        flush,
   output logic        idExBubble,
   output logic        excRedirect,
   output logic        mdBusy,
   output logic [31:0] stallCycles
);

   typedef enum logic [1:0] {RUN, MD_BUSY, EXC_FLUSH} state_t;

   // The mdStart cycle is the first frozen cycle, so MD_BUSY covers the remaining LATENCY-1.
   localparam logic [CNT_W-1:0] MD_RELOAD = (MD_LATENCY > 1) ? CNT_W'(MD_LATENCY - 2) : '0;

   state_t           state, stateNext;
   logic [CNT_W-1:0] mdCnt, mdCntNext;
   logic             luh;

   assign luh = exMemRead && (exRt != 5'd0) && ((exRt == idRs) || (exRt == idRt));

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= RUN;
         mdCnt <= '0;
      end else begin
         state <= stateNext;
         mdCnt <= mdCntNext;
      end
   end

   always_comb begin
      stateNext   = state;
      mdCntNext   = mdCnt;
      pcWrite     = 1'b1;
      IFIDWrite   = 1'b1;
      flush       = 1'b0;
      idExBubble  = 1'b0;
      excRedirect = 1'b0;
      mdBusy      = 1'b0;
      if (reset) begin
         pcWrite    = 1'b0;
         IFIDWrite  = 1'b0;
         flush      = 1'b1;
         idExBubble = 1'b1;
      end else if (excReq) begin
         // Redirect to the vector and kill both younger stages; any MD freeze is abandoned.
         flush       = 1'b1;
         idExBubble  = 1'b1;
         excRedirect = 1'b1;
         mdBusy      = (state == MD_BUSY);
         stateNext   = EXC_FLUSH;
         mdCntNext   = '0;
      end else begin
         case (state)
            MD_BUSY: begin
               pcWrite    = 1'b0;
               IFIDWrite  = 1'b0;
               idExBubble = 1'b1;
               mdBusy     = 1'b1;
               if (mdCnt == '0) stateNext = RUN;
               else             mdCntNext = mdCnt - 1'b1;
            end
            EXC_FLUSH: begin
               flush      = 1'b1;
               idExBubble = 1'b1;
               stateNext  = RUN;
            end
            RUN: begin
               if (luh) begin
                  pcWrite    = 1'b0;
                  IFIDWrite  = 1'b0;
                  idExBubble = 1'b1;
               end else if (mdStart) begin
                  // Hold fetch but let the MD op itself advance into EX.
                  pcWrite   = 1'b0;
                  IFIDWrite = 1'b0;
                  if (MD_LATENCY > 1) begin
                     stateNext = MD_BUSY;
                     mdCntNext = MD_RELOAD;
                  end
               end else if (branchTaken || jump) begin
                  flush = 1'b1;
               end
            end
            default: begin
               stateNext = RUN;
               mdCntNext = '0;
            end
         endcase
      end
   end

`ifdef HAZARD_STALL_COUNT_EN
   logic [31:0] stallCnt;

   always_ff @(posedge clock or posedge reset) begin
      if (reset)         stallCnt <= '0;
      else if (!pcWrite) stallCnt <= stallCnt + 32'd1;
   end

   assign stallCycles = stallCnt;
`else
   assign stallCycles = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (MD_LATENCY=4); expected values hand-derived.
module tb_hazard_ctrl;

   logic        clock = 1'b0;
   logic        reset;
   logic [4:0]  idRs, idRt, exRt;
   logic        exMemRead, branchTaken, jump, mdStart, excReq;
   logic        pcWrite, IFIDWrite, flush, idExBubble, excRedirect, mdBusy;
   logic [31:0] stallCycles;

   int checks   = 0;
   int failures = 0;

   hazard_ctrl #(.MD_LATENCY(4), .CNT_W(6)) dut (
      .clock(clock), .reset(reset), .idRs(idRs), .idRt(idRt),
      .exMemRead(exMemRead), .exRt(exRt), .branchTaken(branchTaken), .jump(jump),
      .mdStart(mdStart), .excReq(excReq), .pcWrite(pcWrite), .IFIDWrite(IFIDWrite),
      .flush(flush), .idExBubble(idExBubble), .excRedirect(excRedirect),
      .mdBusy(mdBusy), .stallCycles(stallCycles)
   );

   always #5 clock = ~clock;

   // Output vector order: {pcWrite, IFIDWrite, flush, idExBubble, excRedirect, mdBusy}
   function automatic logic [5:0] outs();
      return {pcWrite, IFIDWrite, flush, idExBubble, excRedirect, mdBusy};
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic idle();
      idRs = 5'd1; idRt = 5'd2; exRt = 5'd0; exMemRead = 1'b0;
      branchTaken = 1'b0; jump = 1'b0; mdStart = 1'b0; excReq = 1'b0;
   endtask

   // Inputs change 1 time unit after the rising edge; outputs sampled on the falling edge.
   task automatic next();
      @(posedge clock);
      #1;
   endtask

   task automatic chkOuts(input string tag, input logic [5:0] exp);
      @(negedge clock);
      chk(tag, 32'(outs()), 32'(exp));
   endtask

   initial begin
      idle();
      reset = 1'b1;
      #2;
      chk("reset_outs", 32'(outs()), 32'(6'b001100));
      chk("reset_stall", stallCycles, 32'd0);
      next(); next();
      reset = 1'b0;
      chkOuts("run_normal", 6'b110000);

      // Load-use on rs, then gone next cycle
      next(); exMemRead = 1'b1; exRt = 5'd8; idRs = 5'd8;
      chkOuts("luh_rs", 6'b000100);
      next(); idle();
      chkOuts("luh_after", 6'b110000);
      // exRt==0 never stalls
      next(); exMemRead = 1'b1; exRt = 5'd0; idRs = 5'd0;
      chkOuts("luh_r0", 6'b110000);
      // Load-use on rt
      next(); idle(); exMemRead = 1'b1; exRt = 5'd5; idRt = 5'd5;
      chkOuts("luh_rt", 6'b000100);
      // Load to unrelated register
      next(); idle(); exMemRead = 1'b1; exRt = 5'd9;
      chkOuts("luh_nomatch", 6'b110000);

      // Branch / jump flush; luh overrides branch
      next(); idle(); branchTaken = 1'b1;
      chkOuts("branch", 6'b111000);
      next(); idle(); jump = 1'b1;
      chkOuts("jump", 6'b111000);
      next(); idle(); branchTaken = 1'b1; exMemRead = 1'b1; exRt = 5'd1;
      chkOuts("branch_luh", 6'b000100);
      // luh also suppresses mdStart
      next(); idle(); mdStart = 1'b1; exMemRead = 1'b1; exRt = 5'd2;
      chkOuts("md_luh", 6'b000100);

      // MD op: 4 frozen cycles, mdBusy on cycles 2-4
      next(); idle(); mdStart = 1'b1;
      chkOuts("md_c1", 6'b000000);
      next(); idle();
      chkOuts("md_c2", 6'b000101);
      next();
      chkOuts("md_c3", 6'b000101);
      next();
      chkOuts("md_c4", 6'b000101);
      next();
      chkOuts("md_done", 6'b110000);

      // Exception on the 2nd cycle of an MD stall
      next(); mdStart = 1'b1;
      chkOuts("mdx_c1", 6'b000000);
      next(); idle(); excReq = 1'b1;
      @(negedge clock);
      chk("mdx_exc", 32'({pcWrite, flush, idExBubble, excRedirect}), 32'(4'b1111));
      next(); idle();
      chkOuts("mdx_excflush", 6'b111100);
      next();
      chkOuts("mdx_run", 6'b110000);

      // Back-to-back exception keeps EXC_FLUSH with redirect
      next(); excReq = 1'b1;
      @(negedge clock);
      chk("exc2_first", 32'({pcWrite, flush, idExBubble, excRedirect, mdBusy}), 32'(5'b11110));
      next();
      @(negedge clock);
      chk("exc2_again", 32'({pcWrite, flush, idExBubble, excRedirect, mdBusy}), 32'(5'b11110));
      next(); idle();
      chkOuts("exc2_flush", 6'b111100);
      next();
      chkOuts("exc2_run", 6'b110000);

      // Async reset in MD_BUSY between edges
      next(); mdStart = 1'b1;
      next(); idle();
      #2 reset = 1'b1;
      #1 chk("async_rst", 32'(outs()), 32'(6'b001100));
      chk("async_rst_cnt", stallCycles, 32'd0);
      next(); next();
      reset = 1'b0;
      chkOuts("rst_release", 6'b110000);
      next();
      chkOuts("rst_norun", 6'b110000);

      // Stall counting: MD(4) + one load-use
      next(); mdStart = 1'b1;
      next(); idle();
      next(); next(); next();
      exMemRead = 1'b1; exRt = 5'd8; idRs = 5'd8;
      chkOuts("cnt_luh", 6'b000100);
      next(); idle();
      next();
      @(negedge clock);
`ifdef HAZARD_STALL_COUNT_EN
      chk("stall_count", stallCycles, 32'd5);
`else
      chk("stall_count", stallCycles, 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      failures++;
      $display("FAIL timeout observed=running expected=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

endmodule
